// File: rtl/param_seq_rotator.sv
// N-bit rotate/shift register executing valid/ready commands up to STEP positions per cycle.
// Optional abort input enabled by defining PARAM_SEQ_ROTATOR_ABORT_EN.
module param_seq_rotator #(
    parameter  int N    = 69,
    parameter  int STEP = 1,
    localparam int AW   = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
`ifdef PARAM_SEQ_ROTATOR_ABORT_EN
    input  logic          abort,
`endif
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_amt,
    input  logic [N-1:0]  cmd_data,
    input  logic          serial_in,
    output logic [N-1:0]  data_out,
    output logic          serial_out,
    output logic          busy,
    output logic          done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_ROL   = 3'd1;
    localparam logic [2:0] OP_ROR   = 3'd2;
    localparam logic [2:0] OP_SHL   = 3'd3;
    localparam logic [2:0] OP_SHR   = 3'd4;
    localparam logic [2:0] OP_SAR   = 3'd5;
    localparam logic [2:0] OP_LOAD  = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  reg_q, reg_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [2:0]    op_q, op_d;
    logic          so_q, so_d;
    logic          done_q, done_d;

    logic [AW-1:0] k_step;
    logic [AW-1:0] sat_amt;
    logic [N-1:0]  lmask, hmask;
    logic [N-1:0]  rol_v, ror_v, shl_v, shr_v, sar_v;
    logic [N-1:0]  fill_v, sign_v;
    logic          abort_hit;

`ifdef PARAM_SEQ_ROTATOR_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // All k-step candidates are formed in parallel; the op selects one.
    always_comb begin
        k_step  = (rem_q < AW'(STEP)) ? rem_q : AW'(STEP);
        sat_amt = (cmd_amt > AW'(N)) ? AW'(N) : cmd_amt;
        lmask   = ~({N{1'b1}} << k_step);
        hmask   = ~({N{1'b1}} >> k_step);
        fill_v  = {N{serial_in}};
        sign_v  = {N{reg_q[N-1]}};
        rol_v   = (reg_q << k_step) | (reg_q >> (AW'(N) - k_step));
        ror_v   = (reg_q >> k_step) | (reg_q << (AW'(N) - k_step));
        shl_v   = (reg_q << k_step) | (fill_v & lmask);
        shr_v   = (reg_q >> k_step) | (fill_v & hmask);
        sar_v   = (reg_q >> k_step) | (sign_v & hmask);
    end

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        rem_d   = rem_q;
        op_d    = op_q;
        so_d    = so_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_NOP:   done_d = 1'b1;
                        OP_LOAD: begin
                            reg_d  = cmd_data;
                            done_d = 1'b1;
                        end
                        OP_CLEAR: begin
                            reg_d  = '0;
                            done_d = 1'b1;
                        end
                        default: begin
                            op_d  = cmd_op;
                            rem_d = sat_amt;
                            if (sat_amt == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                    endcase
                end
            end
            default: begin
                if (abort_hit) begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                end else begin
                    // Left ops eject old[N-k] which lands in rol_v[0];
                    // right ops eject old[k-1] which lands in ror_v[N-1].
                    case (op_q)
                        OP_ROL: begin
                            reg_d = rol_v;
                            so_d  = rol_v[0];
                        end
                        OP_ROR: begin
                            reg_d = ror_v;
                            so_d  = ror_v[N-1];
                        end
                        OP_SHL: begin
                            reg_d = shl_v;
                            so_d  = rol_v[0];
                        end
                        OP_SHR: begin
                            reg_d = shr_v;
                            so_d  = ror_v[N-1];
                        end
                        OP_SAR: begin
                            reg_d = sar_v;
                            so_d  = ror_v[N-1];
                        end
                        default: ;
                    endcase
                    rem_d = rem_q - k_step;
                    if (rem_q == k_step) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            reg_q   <= '0;
            rem_q   <= '0;
            op_q    <= OP_NOP;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            so_q    <= so_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q == S_RUN);
    assign done       = done_q;
    assign data_out   = reg_q;
    assign serial_out = so_q;

endmodule

// File: tb/tb_param_seq_rotator.sv
// Bench for param_seq_rotator: N=8 with STEP=1 and STEP=3 instances on shared stimulus.
// Reference model applies ops one position at a time and derives latency arithmetically.
module tb_param_seq_rotator;

    localparam int N = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic [2:0]      cmd_op;
    logic [3:0]      cmd_amt;
    logic [7:0]      cmd_data;
    logic            serial_in;
`ifdef PARAM_SEQ_ROTATOR_ABORT_EN
    logic            abort;
`endif
    logic [1:0]      rdy;
    logic [1:0]      so;
    logic [1:0]      busy;
    logic [1:0]      done;
    logic [1:0][7:0] dout;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_reg [2];
    logic       m_so  [2];

    always #5 clk = ~clk;

    param_seq_rotator #(.N(N), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst),
`ifdef PARAM_SEQ_ROTATOR_ABORT_EN
        .abort(abort),
`endif
        .cmd_valid(cmd_valid), .cmd_ready(rdy[0]), .cmd_op(cmd_op),
        .cmd_amt(cmd_amt), .cmd_data(cmd_data), .serial_in(serial_in),
        .data_out(dout[0]), .serial_out(so[0]), .busy(busy[0]), .done(done[0])
    );

    param_seq_rotator #(.N(N), .STEP(3)) u_s3 (
        .clk(clk), .rst(rst),
`ifdef PARAM_SEQ_ROTATOR_ABORT_EN
        .abort(abort),
`endif
        .cmd_valid(cmd_valid), .cmd_ready(rdy[1]), .cmd_op(cmd_op),
        .cmd_amt(cmd_amt), .cmd_data(cmd_data), .serial_in(serial_in),
        .data_out(dout[1]), .serial_out(so[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int step_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int runs(input logic [2:0] op, input int amt, input int s);
        int a;
        a = (amt > N) ? N : amt;
        if (op >= 3'd1 && op <= 3'd5 && a > 0) return (a + s - 1) / s;
        return 0;
    endfunction

    // One position at a time; a multi-position step is equivalent.
    task automatic ref_cmd(input logic [2:0] op, input int amt, input logic [7:0] data,
                           input logic sin, input int i);
        int a;
        logic [7:0] r;
        logic o;
        a = (amt > N) ? N : amt;
        r = m_reg[i];
        o = m_so[i];
        case (op)
            3'd1: repeat (a) begin o = r[7]; r = {r[6:0], r[7]}; end
            3'd2: repeat (a) begin o = r[0]; r = {r[0], r[7:1]}; end
            3'd3: repeat (a) begin o = r[7]; r = {r[6:0], sin}; end
            3'd4: repeat (a) begin o = r[0]; r = {sin, r[7:1]}; end
            3'd5: repeat (a) begin o = r[0]; r = {r[7], r[7:1]}; end
            3'd6: r = data;
            3'd7: r = 8'h00;
            default: ;
        endcase
        m_reg[i] = r;
        m_so[i]  = o;
    endtask

    task automatic run_cmd(input logic [2:0] op, input int amt, input logic [7:0] data,
                           input logic sin);
        int exp_r [2];
        int nb [2];
        int nd [2];
        int fd [2];
        int ov;
        ov = 0;
        for (int i = 0; i < 2; i++) begin
            exp_r[i] = runs(op, amt, step_of(i));
            ref_cmd(op, amt, data, sin, i);
            nb[i] = 0;
            nd[i] = 0;
            fd[i] = -1;
        end
        cmd_op    = op;
        cmd_amt   = amt[3:0];
        cmd_data  = data;
        serial_in = sin;
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (busy[i]) nb[i]++;
                if (done[i]) begin
                    nd[i]++;
                    if (fd[i] < 0) fd[i] = t;
                end
                if (busy[i] && done[i]) ov++;
            end
            cycle();
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (nb[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL busy_cycles[%0d] op=%0d amt=%0d: got %0d exp %0d",
                         i, op, amt, nb[i], exp_r[i]);
            end
            checks++;
            if (fd[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL done_time[%0d] op=%0d amt=%0d: got %0d exp %0d",
                         i, op, amt, fd[i], exp_r[i]);
            end
            checks++;
            if (nd[i] !== 1) begin
                errors++;
                $display("FAIL done_pulses[%0d] op=%0d: got %0d exp 1", i, op, nd[i]);
            end
            checks++;
            if (dout[i] !== m_reg[i]) begin
                errors++;
                $display("FAIL data_out[%0d] op=%0d amt=%0d: got %h exp %h",
                         i, op, amt, dout[i], m_reg[i]);
            end
            checks++;
            if (so[i] !== m_so[i]) begin
                errors++;
                $display("FAIL serial_out[%0d] op=%0d amt=%0d: got %b exp %b",
                         i, op, amt, so[i], m_so[i]);
            end
        end
        checks++;
        if (ov !== 0) begin
            errors++;
            $display("FAIL busy_done_overlap: got %0d exp 0", ov);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({dout[i], so[i], busy[i], done[i], rdy[i]} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL %s[%0d]: got dout=%h so=%b busy=%b done=%b rdy=%b exp 00 0 0 0 1",
                         tag, i, dout[i], so[i], busy[i], done[i], rdy[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        check_reset_state("reset_initial");
        run_cmd(3'd6, 0, 8'hB1, 1'b0);
        cmd_op    = 3'd1;
        cmd_amt   = 4'd5;
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        check_reset_state("reset_mid_run");
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_reg[i] = 8'h00;
            m_so[i]  = 1'b0;
        end
        cycle();
    endtask

    task automatic test_rol();
        run_cmd(3'd6, 0, 8'hB1, 1'b0);
        run_cmd(3'd1, 3, 8'h00, 1'b0);
        checks++;
        if ({dout[0], so[0]} !== {8'h8D, 1'b1}) begin
            errors++;
            $display("FAIL rol_const: got %h/%b exp 8d/1", dout[0], so[0]);
        end
    endtask

    task automatic test_ror_step3();
        run_cmd(3'd6, 0, 8'h01, 1'b0);
        run_cmd(3'd2, 5, 8'h00, 1'b0);
        checks++;
        if (dout[1] !== 8'h08) begin
            errors++;
            $display("FAIL ror_step3_const: got %h exp 08", dout[1]);
        end
    endtask

    task automatic test_sar_shl_sat();
        run_cmd(3'd6, 0, 8'h90, 1'b0);
        run_cmd(3'd5, 2, 8'h00, 1'b0);
        checks++;
        if (dout[0] !== 8'hE4) begin
            errors++;
            $display("FAIL sar_const: got %h exp e4", dout[0]);
        end
        run_cmd(3'd3, 10, 8'h00, 1'b1);
        checks++;
        if (dout[0] !== 8'hFF) begin
            errors++;
            $display("FAIL shl_sat_const: got %h exp ff", dout[0]);
        end
    endtask

    task automatic test_hold_off();
        logic seen;
        run_cmd(3'd6, 0, 8'h1E, 1'b0);
        for (int i = 0; i < 2; i++) begin
            ref_cmd(3'd1, 4, 8'h00, 1'b0, i);
        end
        cmd_op    = 3'd1;
        cmd_amt   = 4'd4;
        cmd_valid = 1'b1;
        cycle();
        cmd_op   = 3'd6;
        cmd_data = 8'h55;
        seen     = 1'b0;
        for (int t = 0; t < 12 && !seen; t++) begin
            if (busy[0]) begin
                checks++;
                if (rdy[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_ready: got %b exp 0", rdy[0]);
                end
            end
            if (done[0]) begin
                seen = 1'b1;
                checks++;
                if (dout[0] !== m_reg[0]) begin
                    errors++;
                    $display("FAIL hold_done_data: got %h exp %h", dout[0], m_reg[0]);
                end
            end
            cycle();
        end
        cmd_valid = 1'b0;
        checks++;
        if (!seen || dout[0] !== 8'h55) begin
            errors++;
            $display("FAIL hold_load: got %h seen=%b exp 55", dout[0], seen);
        end
        for (int i = 0; i < 2; i++) ref_cmd(3'd6, 0, 8'h55, 1'b0, i);
        cycle();
        run_cmd(3'd1, 0, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        cmd_op    = 3'd6;
        cmd_valid = 1'b1;
        for (int n = 0; n < 6; n++) begin
            d        = 8'($urandom);
            cmd_data = d;
            cycle();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dout[i] !== d) begin
                    errors++;
                    $display("FAIL b2b_load[%0d]: got %h exp %h", i, dout[i], d);
                end
                m_reg[i] = d;
            end
        end
        cmd_valid = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            run_cmd(3'($urandom), int'($urandom_range(0, 15)), 8'($urandom), 1'($urandom));
        end
    endtask

`ifdef PARAM_SEQ_ROTATOR_ABORT_EN
    task automatic test_abort();
        run_cmd(3'd6, 0, 8'h01, 1'b0);
        cmd_op    = 3'd1;
        cmd_amt   = 4'd6;
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        cycle();
        cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        checks++;
        if ({dout[0], so[0], rdy[0], busy[0], done[0]} !== {8'h04, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_state: got %h so=%b rdy=%b busy=%b done=%b exp 04 0 1 0 0",
                     dout[0], so[0], rdy[0], busy[0], done[0]);
        end
        checks++;
        if (dout[1] !== 8'h40) begin
            errors++;
            $display("FAIL abort_step3_done: got %h exp 40", dout[1]);
        end
        cycle();
        checks++;
        if (done[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got %b exp 0", done[0]);
        end
        m_reg[0] = 8'h04;
        m_so[0]  = 1'b0;
        m_reg[1] = 8'h40;
        m_so[1]  = 1'b0;
        run_cmd(3'd2, 2, 8'h00, 1'b0);
    endtask
`endif

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_amt   = 4'd0;
        cmd_data  = 8'h00;
        serial_in = 1'b0;
`ifdef PARAM_SEQ_ROTATOR_ABORT_EN
        abort = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            m_reg[i] = 8'h00;
            m_so[i]  = 1'b0;
        end
        test_reset();
        test_rol();
        test_ror_step3();
        test_sar_shl_sat();
        test_hold_off();
        test_back_to_back();
        test_random();
`ifdef PARAM_SEQ_ROTATOR_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
